w5300_bus_arbiter: RTL and testbench

- Shares the single W5300 parallel register interface among N_REQ independent requesters, e.g. socket TX, socket RX, config/init and interrupt service.
- Performs round-robin arbitration and issues one register transaction at a time to the interface block.
- Supports short locked bursts, detects interface timeouts, and holds off all traffic until the interface reports its reset/init sequence complete.

---
 rtl/w5300_pkg.sv | 19 +
 rtl/w5300_rr_pick.sv | 39 +++
 rtl/w5300_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_w5300_bus_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w5300_pkg.sv
// Shared definitions for the W5300 register-bus arbiter: FSM encodings and
// the default bus geometry of the W5300 parallel host interface.
package w5300_pkg;

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;

    // Read data returned to a requester whose transaction failed.
    localparam logic [DEF_DATA_W-1:0] ERR_RDATA = 16'hFFFF;

endpackage

// File: rtl/w5300_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// i_start, wrapping modulo N_REQ.
module w5300_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int               w_sum;
    logic [IDX_W-1:0] w_cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_sum    = 0;
        w_cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = int'(i_start) + k;
            if (w_sum >= N_REQ) begin
                w_sum = w_sum - N_REQ;
            end
            w_cand = IDX_W'(w_sum);
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/w5300_bus_arbiter.sv
// Round-robin arbiter sharing the W5300 register interface between N_REQ
// requesters, one transaction at a time, with locked bursts and a timeout.
module w5300_bus_arbiter
    import w5300_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int MAX_BURST     = 8,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        lock,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic [N_REQ-1:0]        err,
    output logic [DATA_W-1:0]       rdata,
    input  logic                    if_ready,
    output logic                    if_start,
    output logic                    if_we,
    output logic [ADDR_W-1:0]       if_addr,
    output logic [DATA_W-1:0]       if_wdata,
    input  logic [DATA_W-1:0]       if_rdata,
    input  logic                    if_done
);

    localparam int IDX_W  = $clog2(N_REQ);
    localparam int TCNT_W = $clog2(TIMEOUT_TICKS + 1);

    state_t              r_state;
    logic [N_REQ-1:0]    r_gnt;
    logic [IDX_W-1:0]    r_gidx;
    logic [N_REQ-1:0]    r_done;
    logic [N_REQ-1:0]    r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_if_start;
    logic                r_if_we;
    logic [ADDR_W-1:0]   r_if_addr;
    logic [DATA_W-1:0]   r_if_wdata;
    logic [IDX_W-1:0]    r_ptr;
    logic                r_first;
    logic [7:0]          r_burst;
    logic [TCNT_W-1:0]   r_tcnt;

    logic [IDX_W-1:0]    w_start;
    logic [N_REQ-1:0]    w_win_onehot;
    logic [IDX_W-1:0]    w_win_idx;
    logic                w_win_valid;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic [TCNT_W-1:0]   w_tcnt_inc;
    logic                w_timeout;
    logic                w_burst_more;
    logic                w_continue;

    // Until the first grant is released the search starts at requester 0.
    assign w_start = (r_first || r_ptr == IDX_W'(N_REQ - 1)) ? '0 : r_ptr + IDX_W'(1);

    w5300_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req    (req),
        .i_start  (w_start),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    // Arbitration picks from the winner; a burst continuation reuses the grant.
    assign w_sel_idx = (r_state == S_IDLE) ? w_win_idx : r_gidx;

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel_idx == IDX_W'(i)) begin
                w_sel_we    = we[i];
                w_sel_addr  = addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_tcnt_inc   = (r_tcnt == '1) ? r_tcnt : r_tcnt + TCNT_W'(1);
    assign w_timeout    = (w_tcnt_inc >= TCNT_W'(TIMEOUT_TICKS));
    assign w_burst_more = ({1'b0, r_burst} + 9'd1) < 9'(MAX_BURST);
    assign w_continue   = (r_err == '0) && lock[r_gidx] && req[r_gidx] && w_burst_more;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_WAIT_INIT;
            r_gnt      <= '0;
            r_gidx     <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_rdata    <= '0;
            r_if_start <= 1'b0;
            r_if_we    <= 1'b0;
            r_if_addr  <= '0;
            r_if_wdata <= '0;
            r_ptr      <= '0;
            r_first    <= 1'b1;
            r_burst    <= '0;
            r_tcnt     <= '0;
        end else begin
            r_if_start <= 1'b0;
            r_done     <= '0;
            r_err      <= '0;
            case (r_state)
                S_WAIT_INIT: begin
                    if (if_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (if_ready && w_win_valid) begin
                        r_gnt      <= w_win_onehot;
                        r_gidx     <= w_win_idx;
                        r_if_we    <= w_sel_we;
                        r_if_addr  <= w_sel_addr;
                        r_if_wdata <= w_sel_wdata;
                        r_burst    <= '0;
                        r_if_start <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tcnt  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_tcnt <= w_tcnt_inc;
                    if (if_done) begin
                        if (!r_if_we) begin
                            r_rdata <= if_rdata;
                        end
                        r_done  <= r_gnt;
                        r_state <= S_DONE;
                    end else if (w_timeout || !if_ready) begin
                        r_rdata <= '1;
                        r_done  <= r_gnt;
                        r_err   <= r_gnt;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_continue) begin
                        r_if_we    <= w_sel_we;
                        r_if_addr  <= w_sel_addr;
                        r_if_wdata <= w_sel_wdata;
                        r_burst    <= r_burst + 8'd1;
                        r_if_start <= 1'b1;
                        r_state    <= S_ISSUE;
                    end else begin
                        r_gnt   <= '0;
                        r_ptr   <= r_gidx;
                        r_first <= 1'b0;
                        r_state <= (r_err != '0) ? S_WAIT_INIT : S_IDLE;
                    end
                end
                default: r_state <= S_WAIT_INIT;
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign err      = r_err;
    assign rdata    = r_rdata;
    assign if_start = r_if_start;
    assign if_we    = r_if_we;
    assign if_addr  = r_if_addr;
    assign if_wdata = r_if_wdata;

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Directed bench for w5300_bus_arbiter with a small W5300 interface model
// whose response latency is set per scenario (0 = never responds).
module tb_w5300_bus_arbiter;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req, lock, we;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]    gnt, done, err;
    logic [DW-1:0]    rdata;
    logic             if_ready, if_start, if_we, if_done;
    logic [AW-1:0]    if_addr;
    logic [DW-1:0]    if_wdata, if_rdata;

    int n_vec  = 0;
    int n_miss = 0;
    int mdl_lat = 0;
    int mdl_cnt = 0;

    w5300_bus_arbiter #(
        .N_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(3), .TIMEOUT_TICKS(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we),
        .addr(addr), .wdata(wdata), .gnt(gnt), .done(done), .err(err),
        .rdata(rdata), .if_ready(if_ready), .if_start(if_start), .if_we(if_we),
        .if_addr(if_addr), .if_wdata(if_wdata), .if_rdata(if_rdata),
        .if_done(if_done)
    );

    always #5 clk = ~clk;

    // Interface model: if_done pulses mdl_lat cycles after the if_start cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            mdl_cnt = 0;
            if_done = 1'b0;
        end else begin
            if_done = 1'b0;
            if (mdl_cnt > 0) begin
                mdl_cnt = mdl_cnt - 1;
                if (mdl_cnt == 0) if_done = 1'b1;
            end
            if (if_start && mdl_lat > 0) mdl_cnt = mdl_lat;
        end
    end

    task automatic do_reset(input logic rdy, input int lat, input logic [DW-1:0] rd);
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        if_ready = rdy; mdl_lat = lat; if_rdata = rd;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        if_ready = 1'b0; mdl_lat = 0; if_rdata = '0;
        #1;
        n_vec++; if ({gnt, done, err} !== 12'h000) begin n_miss++; $display("FAIL reset_gnt_done_err: got %h want 000", {gnt, done, err}); end
        n_vec++; if (rdata !== 16'h0000) begin n_miss++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
        n_vec++; if ({if_start, if_we} !== 2'b00) begin n_miss++; $display("FAIL reset_if_ctrl: got %b want 00", {if_start, if_we}); end
        n_vec++; if ({if_addr, if_wdata} !== 26'h0) begin n_miss++; $display("FAIL reset_if_bus: got %h want 0", {if_addr, if_wdata}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (gnt !== 4'b0000 || if_start !== 1'b0) begin n_miss++; $display("FAIL reset_release_idle: gnt %b start %b want 0000 0", gnt, if_start); end
    endtask

    task automatic test_init_gating();
        int bad = 0;
        do_reset(1'b0, 1, 16'h0000);
        req[0] = 1'b1;
        addr[0*AW +: AW] = 10'h005;
        repeat (100) begin
            @(negedge clk);
            if (if_start !== 1'b0 || gnt !== 4'b0000) bad++;
        end
        n_vec++; if (bad !== 0) begin n_miss++; $display("FAIL init_gate_hold: %0d busy cycles, want 0", bad); end
        if_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (if_start !== 1'b0) begin n_miss++; $display("FAIL init_gate_early: start %b want 0", if_start); end
        @(negedge clk);
        n_vec++; if (if_start !== 1'b1 || gnt !== 4'b0001) begin n_miss++; $display("FAIL init_gate_start: start %b gnt %b want 1 0001", if_start, gnt); end
        n_vec++; if (if_addr !== 10'h005) begin n_miss++; $display("FAIL init_gate_addr: got %h want 005", if_addr); end
        req = '0;
    endtask

    task automatic test_single_read();
        int g_cyc = -1, s_cyc = -1, d_cyc = -1, starts = 0;
        logic [NR-1:0] g_val = '0, d_val = '0, e_val = '1;
        logic [DW-1:0] rd = '0;
        logic [AW-1:0] ad = '0;
        do_reset(1'b1, 3, 16'h5300);
        req[1] = 1'b1; we[1] = 1'b0;
        addr[1*AW +: AW] = 10'h200;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (gnt !== 4'b0000 && g_cyc < 0) begin g_cyc = k; g_val = gnt; end
            if (if_start === 1'b1) begin starts++; s_cyc = k; ad = if_addr; end
            if (done !== 4'b0000 && d_cyc < 0) begin
                d_cyc = k; d_val = done; e_val = err; rd = rdata;
                req = '0;
            end
        end
        n_vec++; if (g_cyc !== 1 || g_val !== 4'b0010) begin n_miss++; $display("FAIL read_gnt: cycle %0d gnt %b want 1 0010", g_cyc, g_val); end
        n_vec++; if (starts !== 1 || s_cyc !== 1) begin n_miss++; $display("FAIL read_start: %0d starts at %0d want 1 at 1", starts, s_cyc); end
        n_vec++; if (ad !== 10'h200) begin n_miss++; $display("FAIL read_addr: got %h want 200", ad); end
        n_vec++; if (d_cyc !== 5 || d_val !== 4'b0010) begin n_miss++; $display("FAIL read_done: cycle %0d done %b want 5 0010", d_cyc, d_val); end
        n_vec++; if (rd !== 16'h5300) begin n_miss++; $display("FAIL read_rdata: got %h want 5300", rd); end
        n_vec++; if (e_val !== 4'b0000) begin n_miss++; $display("FAIL read_err: got %b want 0000", e_val); end
        n_vec++; if (gnt !== 4'b0000 || done !== 4'b0000) begin n_miss++; $display("FAIL read_release: gnt %b done %b want 0000 0000", gnt, done); end
    endtask

    task automatic test_fairness();
        logic [NR-1:0] exp_oh [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        logic [NR-1:0] got_oh [4];
        int n = 0;
        int errs = 0;
        do_reset(1'b1, 1, 16'h0000);
        req = 4'b0101;
        for (int k = 0; k < 80 && n < 4; k++) begin
            @(negedge clk);
            if (done !== 4'b0000) begin
                got_oh[n] = done;
                if (err !== 4'b0000) errs++;
                n++;
            end
        end
        req = '0;
        n_vec++; if (n !== 4) begin n_miss++; $display("FAIL fair_count: %0d completions want 4", n); end
        for (int i = 0; i < n; i++) begin
            n_vec++; if (got_oh[i] !== exp_oh[i]) begin n_miss++; $display("FAIL fair_order[%0d]: got %b want %b", i, got_oh[i], exp_oh[i]); end
        end
        n_vec++; if (errs !== 0) begin n_miss++; $display("FAIL fair_err: %0d errors want 0", errs); end
    endtask

    task automatic test_back_to_back();
        int st_cyc [5];
        int dn_cyc [5];
        int zero_cnt [6] = '{0, 0, 0, 0, 0, 0};
        int exp_gap [5] = '{0, 1, 1, 2, 1};
        logic [AW-1:0] st_addr [5];
        logic [DW-1:0] st_wd [5];
        logic          st_we [5];
        int ns = 0, idx = 0, cyc = 0;
        do_reset(1'b1, 2, 16'hBEEF);
        req[3] = 1'b1; lock[3] = 1'b1; we[3] = 1'b1;
        addr[3*AW +: AW] = 10'h010;
        wdata[3*DW +: DW] = 16'hA000;
        while (idx < 5 && cyc < 150) begin
            @(negedge clk);
            cyc++;
            if (if_start === 1'b1 && ns < 5) begin
                st_cyc[ns] = cyc; st_addr[ns] = if_addr; st_wd[ns] = if_wdata; st_we[ns] = if_we;
                ns++;
            end
            if (gnt === 4'b0000 && ns > 0) zero_cnt[ns]++;
            if (done[3] === 1'b1) begin
                dn_cyc[idx] = cyc;
                idx++;
                if (idx == 5) begin
                    req = '0; lock = '0;
                end else begin
                    addr[3*AW +: AW]  = AW'(10'h010 + idx);
                    wdata[3*DW +: DW] = DW'(16'hA000 + idx);
                end
            end
        end
        n_vec++; if (ns !== 5 || idx !== 5) begin n_miss++; $display("FAIL burst_count: %0d starts %0d dones want 5 5", ns, idx); end
        for (int i = 0; i < ns; i++) begin
            n_vec++;
            if (st_addr[i] !== AW'(10'h010 + i) || st_wd[i] !== DW'(16'hA000 + i) || st_we[i] !== 1'b1) begin
                n_miss++;
                $display("FAIL burst_txn[%0d]: addr %h wdata %h we %b want %h %h 1", i, st_addr[i], st_wd[i], st_we[i], AW'(10'h010 + i), DW'(16'hA000 + i));
            end
        end
        for (int i = 1; i < ns && i <= idx; i++) begin
            n_vec++; if (st_cyc[i] - dn_cyc[i-1] !== exp_gap[i]) begin n_miss++; $display("FAIL burst_gap[%0d]: got %0d want %0d", i, st_cyc[i] - dn_cyc[i-1], exp_gap[i]); end
        end
        n_vec++; if (zero_cnt[1] + zero_cnt[2] + zero_cnt[4] !== 0) begin n_miss++; $display("FAIL burst_gnt_held: %0d idle cycles inside bursts want 0", zero_cnt[1] + zero_cnt[2] + zero_cnt[4]); end
        n_vec++; if (zero_cnt[3] < 1) begin n_miss++; $display("FAIL burst_cap_release: %0d idle cycles after cap want >=1", zero_cnt[3]); end
        n_vec++; if (rdata !== 16'h0000) begin n_miss++; $display("FAIL burst_rdata_kept: got %h want 0000", rdata); end
    endtask

    task automatic test_timeout();
        int s_cyc = -1, d_cyc = -1, bad = 0, st = -1;
        logic [NR-1:0] d_val = '0, e_val = '0;
        logic [DW-1:0] rd = '0;
        do_reset(1'b1, 0, 16'h1234);
        req[2] = 1'b1; we[2] = 1'b0;
        addr[2*AW +: AW] = 10'h3FF;
        for (int k = 1; k <= 60 && d_cyc < 0; k++) begin
            @(negedge clk);
            if (if_start === 1'b1) s_cyc = k;
            if (done !== 4'b0000) begin
                d_cyc = k; d_val = done; e_val = err; rd = rdata;
                req = '0; if_ready = 1'b0;
            end
        end
        n_vec++; if (s_cyc < 0 || d_cyc - s_cyc !== 17) begin n_miss++; $display("FAIL tmo_latency: start %0d done %0d want gap 17", s_cyc, d_cyc); end
        n_vec++; if (d_val !== 4'b0100 || e_val !== 4'b0100) begin n_miss++; $display("FAIL tmo_flags: done %b err %b want 0100 0100", d_val, e_val); end
        n_vec++; if (rd !== 16'hFFFF) begin n_miss++; $display("FAIL tmo_rdata: got %h want FFFF", rd); end
        req[0] = 1'b1;
        addr[0*AW +: AW] = 10'h001;
        repeat (10) begin
            @(negedge clk);
            if (if_start !== 1'b0 || gnt !== 4'b0000) bad++;
        end
        n_vec++; if (bad !== 0) begin n_miss++; $display("FAIL tmo_wait_init: %0d busy cycles want 0", bad); end
        if_ready = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            if (if_start === 1'b1 && st < 0) st = k;
        end
        n_vec++; if (st !== 2 || gnt !== 4'b0001) begin n_miss++; $display("FAIL tmo_recover: start at %0d gnt %b want 2 0001", st, gnt); end
        req = '0;
    endtask

    task automatic test_reset_mid_txn();
        int seen = 0, early_done = 0;
        logic [NR-1:0] first_gnt = '0;
        do_reset(1'b1, 0, 16'h0000);
        req[3] = 1'b1; we[3] = 1'b1;
        addr[3*AW +: AW] = 10'h155;
        wdata[3*DW +: DW] = 16'h5A5A;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (if_start === 1'b1) seen = 1;
        end
        n_vec++; if (seen !== 1) begin n_miss++; $display("FAIL rst_mid_start: no if_start seen, want 1"); end
        repeat (3) @(negedge clk);
        n_vec++; if (if_addr !== 10'h155 || gnt !== 4'b1000) begin n_miss++; $display("FAIL rst_mid_pre: addr %h gnt %b want 155 1000", if_addr, gnt); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (gnt !== 4'b0000 || done !== 4'b0000 || if_start !== 1'b0) begin n_miss++; $display("FAIL rst_mid_ctrl: gnt %b done %b start %b want 0", gnt, done, if_start); end
        n_vec++; if (if_addr !== 10'h000 || if_wdata !== 16'h0000 || if_we !== 1'b0) begin n_miss++; $display("FAIL rst_mid_bus: addr %h wdata %h we %b want 0", if_addr, if_wdata, if_we); end
        @(negedge clk);
        req = 4'b1001; mdl_lat = 2;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20 && first_gnt == 4'b0000; k++) begin
            @(negedge clk);
            if (done !== 4'b0000) early_done++;
            if (gnt !== 4'b0000) first_gnt = gnt;
        end
        n_vec++; if (early_done !== 0) begin n_miss++; $display("FAIL rst_mid_no_done: %0d done pulses want 0", early_done); end
        n_vec++; if (first_gnt !== 4'b0001) begin n_miss++; $display("FAIL rst_mid_first_gnt: got %b want 0001", first_gnt); end
        req = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        if_ready = 1'b0; if_rdata = '0; if_done = 1'b0;
        test_reset();
        test_init_gating();
        test_single_read();
        test_fairness();
        test_back_to_back();
        test_timeout();
        test_reset_mid_txn();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
